// File: rtl/inverse_mapping_dmac_replace.sv
// Packet-buffer reader that rewrites the head-line DMAC with the lookup result and frees the buffer.
// Optional macro DROP_UNMATCHED_EN: unmatched frames are released without being read or forwarded.
module inverse_mapping_dmac_replace #(
    parameter int LINE_AW = 7,
    parameter int RAM_LAT = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [47:0]  iv_dmac,
    input  logic [8:0]   iv_bufid,
    input  logic         i_lookup_table_match_flag,
    input  logic         i_descriptor_wr,
    output logic         o_descriptor_ready,
    output logic [15:0]  ov_pkt_ram_raddr,
    output logic         o_pkt_ram_rd,
    input  logic [133:0] iv_pkt_ram_rdata,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    input  logic         i_fifo_almost_full,
    output logic [8:0]   ov_release_bufid,
    output logic         o_release_wr,
    output logic [15:0]  ov_unmatch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_RELEASE
    } state_t;

    state_t               state_reg, state_next;
    logic [47:0]          dmac_reg;
    logic [8:0]           bufid_reg;
    logic                 flag_reg;
    logic [LINE_AW-1:0]   line_reg;
    logic                 tail_seen_reg;
    logic [RAM_LAT-1:0]   vld_reg;
    logic [RAM_LAT-1:0]   last_reg;
    logic [133:0]         data_reg;
    logic                 data_wr_reg;
    logic                 ready_reg;
    logic [15:0]          unmatch_reg;

    logic                 accept;
    logic                 rd_next;
    logic                 ret_valid;
    logic                 ret_last;
    logic                 emit;
    logic                 tail_hit;
    logic                 line_end;
    logic [133:0]         line_shaped;

    assign accept    = ready_reg && i_descriptor_wr;
    assign ret_valid = vld_reg[RAM_LAT-1];
    assign ret_last  = last_reg[RAM_LAT-1];
    // Anything returning after the tail is an over-read and is dropped.
    assign emit      = ret_valid && !tail_seen_reg;
    assign tail_hit  = emit && (iv_pkt_ram_rdata[133] || ret_last);
    assign line_end  = &line_reg;

    always_comb begin
        line_shaped = iv_pkt_ram_rdata;
        if (flag_reg && iv_pkt_ram_rdata[132]) begin
            line_shaped[127:80] = dmac_reg;
        end
        if (ret_last) begin
            line_shaped[133:128] = 6'b10_1111;
        end
    end

    always_comb begin
        state_next = state_reg;
        rd_next    = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
`ifdef DROP_UNMATCHED_EN
                    state_next = i_lookup_table_match_flag ? S_READ : S_RELEASE;
`else
                    state_next = S_READ;
`endif
                end
            end
            S_READ: begin
                if (tail_hit) begin
                    state_next = S_DRAIN;
                end else if (!i_fifo_almost_full) begin
                    rd_next = 1'b1;
                    if (line_end) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (vld_reg == '0) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= S_IDLE;
            dmac_reg      <= '0;
            bufid_reg     <= '0;
            flag_reg      <= 1'b0;
            line_reg      <= '0;
            tail_seen_reg <= 1'b0;
            vld_reg[0]    <= 1'b0;
            last_reg[0]   <= 1'b0;
            data_reg      <= '0;
            data_wr_reg   <= 1'b0;
            ready_reg     <= 1'b0;
            unmatch_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            ready_reg   <= (state_next == S_IDLE);
            vld_reg[0]  <= rd_next;
            last_reg[0] <= rd_next && line_end;
            data_wr_reg <= emit;
            if (emit) begin
                data_reg <= line_shaped;
            end
            if (accept) begin
                dmac_reg      <= iv_dmac;
                bufid_reg     <= iv_bufid;
                flag_reg      <= i_lookup_table_match_flag;
                line_reg      <= '0;
                tail_seen_reg <= 1'b0;
                if (!i_lookup_table_match_flag && unmatch_reg != 16'hFFFF) begin
                    unmatch_reg <= unmatch_reg + 16'd1;
                end
            end else begin
                if (rd_next) begin
                    line_reg <= line_reg + 1'b1;
                end
                if (tail_hit) begin
                    tail_seen_reg <= 1'b1;
                end
            end
        end
    end

    // Read-valid and wrap-marker pipelines track the RAM latency.
    generate
        for (genvar gi = 1; gi < RAM_LAT; gi++) begin : g_lat
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    vld_reg[gi]  <= 1'b0;
                    last_reg[gi] <= 1'b0;
                end else begin
                    vld_reg[gi]  <= vld_reg[gi-1];
                    last_reg[gi] <= last_reg[gi-1];
                end
            end
        end
    endgenerate

    assign o_descriptor_ready = ready_reg;
    assign o_pkt_ram_rd       = rd_next;
    assign ov_pkt_ram_raddr   = 16'({bufid_reg, line_reg});
    assign ov_data            = data_reg;
    assign o_data_wr          = data_wr_reg;
    assign o_release_wr       = (state_reg == S_RELEASE);
    assign ov_release_bufid   = o_release_wr ? bufid_reg : 9'd0;
    assign ov_unmatch_cnt     = unmatch_reg;

endmodule
